rep_seq_checker: RTL and testbench

// Synthesizable hardware monitor for the repetition-operator property family:

---
 rtl/rep_seq_checker.sv | 115 +++++++++++
 tb/tb_rep_seq_checker.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_seq_checker.sv
// Repetition-property monitor: $rose(a) |-> b[->N] ##1 b (GOTO) or b[=N] ##1 b (NONCON).
// Verdict pulses one cycle after the deciding edge; no backpressure, every edge is consumed.
module rep_seq_checker #(
  parameter int REP_N   = 3,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a,
  input  logic                       b,
  output logic                       busy,
  output logic [$clog2(REP_N+1)-1:0] hit_cnt,
  output logic                       pass,
  output logic                       fail,
  output logic [CNT_W-1:0]           pass_cnt,
  output logic [CNT_W-1:0]           fail_cnt
);
  localparam int HIT_W = $clog2(REP_N + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(REP_N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COUNT, FINAL} state_t;

  state_t           state_q, state_d;
  logic             a_q;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic             rose;

  assign rose = a & ~a_q;

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    timer_d = timer_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;

    case (state_q)
      IDLE: begin
        if (rose) begin
          state_d  = (b && REP_N == 1) ? FINAL : COUNT;
          hit_d    = '0;
          hit_d[0] = b;
          timer_d  = '0;
        end
      end
      COUNT: begin
        if (b) begin
          hit_d = hit_q + 1'b1;
          if (hit_q == HIT_LAST) state_d = FINAL;
        end
      end
      FINAL: begin
        if (b)              pass_d = 1'b1;
        else if (MODE == 0) fail_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A verdict on the timeout edge takes priority over the timeout fail.
    if (state_q != IDLE && !pass_d && !fail_d) begin
      timer_d = timer_q + 1'b1;
      if (TIMEOUT != 0 && timer_q == TMR_LAST) fail_d = 1'b1;
    end

    if (pass_d || fail_d) begin
      state_d = IDLE;
      hit_d   = '0;
      timer_d = '0;
    end

    if (pass_d && pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
    if (fail_d && fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 1'b0;
      hit_q   <= '0;
      timer_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a;
      hit_q   <= hit_d;
      timer_q <= timer_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign hit_cnt  = hit_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pass_cnt = pcnt_q;
  assign fail_cnt = fcnt_q;

endmodule

// File: tb/tb_rep_seq_checker.sv
// Bench for rep_seq_checker: three parameterisations share one a/b stream;
// expected verdict pulses are queued with the stimulus and popped as pulses appear.
module tb_rep_seq_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;

  always #5 clk = ~clk;

  logic g_busy, g_pass, g_fail;
  logic [1:0] g_hit;
  logic [3:0] g_pcnt, g_fcnt;
  logic n_busy, n_pass, n_fail;
  logic [1:0] n_hit;
  logic [15:0] n_pcnt, n_fcnt;
  logic t_busy, t_pass, t_fail;
  logic [1:0] t_hit;
  logic [15:0] t_pcnt, t_fcnt;

  rep_seq_checker #(.REP_N(3), .MODE(0), .TIMEOUT(0), .CNT_W(4)) u_goto (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .busy(g_busy), .hit_cnt(g_hit),
    .pass(g_pass), .fail(g_fail), .pass_cnt(g_pcnt), .fail_cnt(g_fcnt));
  rep_seq_checker #(.REP_N(3), .MODE(1), .TIMEOUT(0), .CNT_W(16)) u_noncon (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .busy(n_busy), .hit_cnt(n_hit),
    .pass(n_pass), .fail(n_fail), .pass_cnt(n_pcnt), .fail_cnt(n_fcnt));
  rep_seq_checker #(.REP_N(3), .MODE(1), .TIMEOUT(8), .CNT_W(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .busy(t_busy), .hit_cnt(t_hit),
    .pass(t_pass), .fail(t_fail), .pass_cnt(t_pcnt), .fail_cnt(t_fcnt));

  int sel = 0;
  logic o_busy, o_pass, o_fail;
  logic [1:0] o_hit;
  logic [15:0] o_pcnt, o_fcnt;

  always_comb begin
    o_busy = g_busy; o_pass = g_pass; o_fail = g_fail; o_hit = g_hit;
    o_pcnt = {12'd0, g_pcnt}; o_fcnt = {12'd0, g_fcnt};
    if (sel == 1) begin
      o_busy = n_busy; o_pass = n_pass; o_fail = n_fail; o_hit = n_hit;
      o_pcnt = n_pcnt; o_fcnt = n_fcnt;
    end else if (sel == 2) begin
      o_busy = t_busy; o_pass = t_pass; o_fail = t_fail; o_hit = t_hit;
      o_pcnt = t_pcnt; o_fcnt = t_fcnt;
    end
  end

  typedef struct {int k; logic is_pass;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  logic [127:0] stim_a, stim_b;
  logic        obs_busy [0:127];
  logic        obs_pass [0:127];
  logic        obs_fail [0:127];
  logic [1:0]  obs_hit  [0:127];
  logic [15:0] obs_pcnt [0:127];
  logic [15:0] obs_fcnt [0:127];

  // Index k holds the outputs as sampled by rising edge k; stim bit k is sampled by edge k.
  task automatic run_trace(input int n);
    rst_n = 1'b0;
    a = stim_a[0];
    b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= n; k++) begin
      a = stim_a[k];
      b = stim_b[k];
      obs_busy[k] = o_busy; obs_pass[k] = o_pass; obs_fail[k] = o_fail;
      obs_hit[k] = o_hit; obs_pcnt[k] = o_pcnt; obs_fcnt[k] = o_fcnt;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_goto_fail();
    exp_t e;
    sel = 0; stim_a = '0; stim_b = '0;
    stim_a[3:2] = 2'b11; stim_b[5:3] = 3'b111;
    exp_q.push_back('{7, 1'b0});
    run_trace(12);
    for (int k = 1; k <= 12; k++) if (obs_pass[k] || obs_fail[k]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL goto_fail_pulse k%0d got pass=%b fail=%b want none", k, obs_pass[k], obs_fail[k]);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || obs_pass[k] !== e.is_pass || obs_fail[k] !== !e.is_pass) begin
          errors++; $display("FAIL goto_fail_pulse got k%0d pass=%b fail=%b want k%0d pass=%b", k, obs_pass[k], obs_fail[k], e.k, e.is_pass);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL goto_fail_missing got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (obs_busy[3] !== 1'b1) begin errors++; $display("FAIL goto_fail_busy got %b want 1", obs_busy[3]); end
    checks++;
    if (obs_hit[6] !== 2'd3) begin errors++; $display("FAIL goto_fail_hit got %0d want 3", obs_hit[6]); end
    checks++;
    if (obs_busy[7] !== 1'b0) begin errors++; $display("FAIL goto_fail_idle got %b want 0", obs_busy[7]); end
    checks++;
    if (obs_fcnt[8] !== 16'd1 || obs_pcnt[8] !== 16'd0) begin
      errors++; $display("FAIL goto_fail_cnt got fail_cnt=%0d pass_cnt=%0d want 1/0", obs_fcnt[8], obs_pcnt[8]);
    end
  endtask

  task automatic test_reset();
    sel = 0; stim_a = '0; stim_b = '0;
    run_trace(3);
    for (int k = 1; k <= 3; k += 2) begin
      checks++;
      if ({obs_busy[k], obs_hit[k], obs_pass[k], obs_fail[k], obs_pcnt[k], obs_fcnt[k]} !== 37'd0) begin
        errors++;
        $display("FAIL reset_state k%0d got busy=%b hit=%0d pass=%b fail=%b pcnt=%0d fcnt=%0d want all 0",
                 k, obs_busy[k], obs_hit[k], obs_pass[k], obs_fail[k], obs_pcnt[k], obs_fcnt[k]);
      end
    end
  endtask

  task automatic test_goto_pass();
    exp_t e;
    sel = 0; stim_a = '0; stim_b = '0;
    stim_a[3:2] = 2'b11; stim_b[5:2] = 4'b1111;
    exp_q.push_back('{6, 1'b1});
    run_trace(10);
    for (int k = 1; k <= 10; k++) if (obs_pass[k] || obs_fail[k]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL goto_pass_pulse k%0d got pass=%b fail=%b want none", k, obs_pass[k], obs_fail[k]);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || obs_pass[k] !== e.is_pass || obs_fail[k] !== !e.is_pass) begin
          errors++; $display("FAIL goto_pass_pulse got k%0d pass=%b fail=%b want k%0d pass=%b", k, obs_pass[k], obs_fail[k], e.k, e.is_pass);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL goto_pass_missing got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (obs_hit[5] !== 2'd3) begin errors++; $display("FAIL goto_pass_hit got %0d want 3", obs_hit[5]); end
    checks++;
    if (obs_hit[6] !== 2'd0 || obs_busy[6] !== 1'b0) begin
      errors++; $display("FAIL goto_pass_clear got hit=%0d busy=%b want 0/0", obs_hit[6], obs_busy[6]);
    end
    checks++;
    if (obs_pcnt[7] !== 16'd1) begin errors++; $display("FAIL goto_pass_cnt got %0d want 1", obs_pcnt[7]); end
  endtask

  task automatic test_noncon_pass();
    exp_t e;
    sel = 1; stim_a = '0; stim_b = '0;
    stim_a[3:2] = 2'b11; stim_b[5:3] = 3'b111; stim_b[12] = 1'b1;
    exp_q.push_back('{13, 1'b1});
    run_trace(16);
    for (int k = 1; k <= 16; k++) if (obs_pass[k] || obs_fail[k]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL noncon_pulse k%0d got pass=%b fail=%b want none", k, obs_pass[k], obs_fail[k]);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || obs_pass[k] !== e.is_pass || obs_fail[k] !== !e.is_pass) begin
          errors++; $display("FAIL noncon_pulse got k%0d pass=%b fail=%b want k%0d pass=%b", k, obs_pass[k], obs_fail[k], e.k, e.is_pass);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL noncon_missing got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    for (int k = 2; k <= 13; k++) begin
      checks++;
      if (obs_busy[k] !== (k >= 3 && k <= 12)) begin
        errors++; $display("FAIL noncon_busy k%0d got %b want %b", k, obs_busy[k], (k >= 3 && k <= 12));
      end
    end
    for (int k = 6; k <= 12; k++) begin
      checks++;
      if (obs_hit[k] !== 2'd3) begin errors++; $display("FAIL noncon_hit k%0d got %0d want 3", k, obs_hit[k]); end
    end
    checks++;
    if (obs_pcnt[14] !== 16'd1) begin errors++; $display("FAIL noncon_cnt got %0d want 1", obs_pcnt[14]); end
  endtask

  task automatic test_noncon_timeout();
    exp_t e;
    sel = 2; stim_a = '0; stim_b = '0;
    stim_a[3:2] = 2'b11; stim_a[7:6] = 2'b11; stim_b[4:3] = 2'b11;
    exp_q.push_back('{11, 1'b0});
    run_trace(20);
    for (int k = 1; k <= 20; k++) if (obs_pass[k] || obs_fail[k]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL timeout_pulse k%0d got pass=%b fail=%b want none", k, obs_pass[k], obs_fail[k]);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || obs_pass[k] !== e.is_pass || obs_fail[k] !== !e.is_pass) begin
          errors++; $display("FAIL timeout_pulse got k%0d pass=%b fail=%b want k%0d pass=%b", k, obs_pass[k], obs_fail[k], e.k, e.is_pass);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL timeout_missing got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (obs_hit[5] !== 2'd2) begin errors++; $display("FAIL timeout_hit got %0d want 2", obs_hit[5]); end
    checks++;
    if (obs_busy[10] !== 1'b1 || obs_busy[11] !== 1'b0) begin
      errors++; $display("FAIL timeout_busy got k10=%b k11=%b want 1/0", obs_busy[10], obs_busy[11]);
    end
    checks++;
    if (obs_fcnt[12] !== 16'd1) begin errors++; $display("FAIL timeout_cnt got %0d want 1", obs_fcnt[12]); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    sel = 0; stim_a = '0; stim_b = '0;
    stim_a[3:2] = 2'b11; stim_b[5:2] = 4'b1111;
    stim_a[9:8] = 2'b11; stim_b[10:8] = 3'b111;
    exp_q.push_back('{6, 1'b1});
    run_trace(10);
    for (int k = 1; k <= 10; k++) if (obs_pass[k] || obs_fail[k]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL arst_pulse k%0d got pass=%b fail=%b want none", k, obs_pass[k], obs_fail[k]);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || obs_pass[k] !== e.is_pass || obs_fail[k] !== !e.is_pass) begin
          errors++; $display("FAIL arst_pulse got k%0d pass=%b fail=%b want k%0d pass=%b", k, obs_pass[k], obs_fail[k], e.k, e.is_pass);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL arst_missing got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (o_busy !== 1'b1 || o_hit !== 2'd3 || o_pcnt !== 16'd1) begin
      errors++; $display("FAIL arst_final got busy=%b hit=%0d pcnt=%0d want 1/3/1", o_busy, o_hit, o_pcnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_hit, o_pass, o_fail, o_pcnt, o_fcnt} !== 37'd0) begin
      errors++; $display("FAIL arst_clear got busy=%b hit=%0d pass=%b fail=%b pcnt=%0d fcnt=%0d want all 0",
                         o_busy, o_hit, o_pass, o_fail, o_pcnt, o_fcnt);
    end
    stim_a = '1; stim_b = '0;
    run_trace(4);
    checks++;
    if (obs_busy[1] !== 1'b0 || obs_busy[2] !== 1'b1 || obs_hit[2] !== 2'd0) begin
      errors++; $display("FAIL arst_restart got busy1=%b busy2=%b hit2=%0d want 0/1/0", obs_busy[1], obs_busy[2], obs_hit[2]);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    sel = 0; stim_a = '0; stim_b = '0;
    for (int i = 0; i < 17; i++) begin
      stim_a[2 + 4*i] = 1'b1;
      stim_b[2 + 4*i] = 1'b1; stim_b[3 + 4*i] = 1'b1; stim_b[4 + 4*i] = 1'b1;
      exp_q.push_back('{6 + 4*i, 1'b0});
    end
    run_trace(72);
    for (int k = 1; k <= 72; k++) if (obs_pass[k] || obs_fail[k]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sat_pulse k%0d got pass=%b fail=%b want none", k, obs_pass[k], obs_fail[k]);
      end else begin
        e = exp_q.pop_front();
        if (e.k != k || obs_pass[k] !== e.is_pass || obs_fail[k] !== !e.is_pass) begin
          errors++; $display("FAIL sat_pulse got k%0d pass=%b fail=%b want k%0d pass=%b", k, obs_pass[k], obs_fail[k], e.k, e.is_pass);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sat_missing got %0d outstanding want 0", exp_q.size()); exp_q.delete();
    end
    checks++;
    if (obs_fcnt[59] !== 16'd14) begin errors++; $display("FAIL sat_cnt14 got %0d want 14", obs_fcnt[59]); end
    checks++;
    if (obs_fcnt[63] !== 16'd15) begin errors++; $display("FAIL sat_cnt15 got %0d want 15", obs_fcnt[63]); end
    checks++;
    if (obs_fcnt[67] !== 16'd15 || obs_fcnt[72] !== 16'd15) begin
      errors++; $display("FAIL sat_stick got k67=%0d k72=%0d want 15/15", obs_fcnt[67], obs_fcnt[72]);
    end
    checks++;
    if (obs_pcnt[72] !== 16'd0) begin errors++; $display("FAIL sat_pass_cnt got %0d want 0", obs_pcnt[72]); end
  endtask

  initial begin
    test_goto_fail();
    test_reset();
    test_goto_pass();
    test_noncon_pass();
    test_noncon_timeout();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
